lsu_mem_initiator: RTL and testbench

LSU_MEM_INITIATOR -- requirements
Module: lsu_mem_initiator

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_extend.sv | 28 ++
 rtl/lsu_mem_initiator.sv | 143 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: FSM states, funct3 codes, size masks.
// Imported by the memory initiator and its load extend helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEAT0,
        S_WAIT0,
        S_BEAT1,
        S_WAIT1,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            2'b00:   m = MASK_B;
            2'b01:   m = MASK_H;
            2'b10:   m = MASK_W;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Aligns two registered load beats to the byte offset and
// zero/sign-extends the selected byte, half or word.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [1:0]  i_a,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [31:0] w_sh;

    assign w_sh = 32'(i_data >> {i_a, 3'b000});

    always_comb begin
        o_result = 32'd0;
        case (i_funct3)
            F3_B:    o_result = {{24{w_sh[7]}}, w_sh[7:0]};
            F3_H:    o_result = {{16{w_sh[15]}}, w_sh[15:0]};
            F3_W:    o_result = w_sh;
            F3_BU:   o_result = {24'd0, w_sh[7:0]};
            F3_HU:   o_result = {16'd0, w_sh[15:0]};
            default: o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store memory initiator: turns one pipeline request into one
// or two word-aligned memory beats and a single completion pulse.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_a;
    logic [29:0] r_base;
    logic [7:0]  r_lanes;
    logic        r_split;
    logic        r_err;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;

    logic [7:0]  w_lanes;
    logic        w_split;
    logic        w_bad;
    logic [63:0] w_wdata64;
    logic        w_accept;
    logic        w_hs;
    logic        w_beat1;
    logic [31:0] w_ext;

    // Lane mask spans two words when the access crosses a boundary
    assign w_lanes   = {4'b0000, size_mask(req_funct3[1:0])} << req_addr[1:0];
    assign w_split   = |w_lanes[7:4];
    assign w_bad     = !f3_legal(req_we, req_funct3) || (w_split && !SPLIT_EN);
    assign w_wdata64 = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
    assign w_accept  = req_valid && req_ready;
    assign w_hs      = mem_valid && mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_a     <= 2'd0;
            r_base  <= 30'd0;
            r_lanes <= 8'd0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 64'd0;
            r_rdata <= 64'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_a     <= req_addr[1:0];
                r_base  <= req_addr[31:2];
                r_lanes <= w_lanes;
                r_split <= w_split;
                r_err   <= w_bad;
                r_wdata <= req_we ? w_wdata64 : 64'd0;
                r_rdata <= 64'd0;
            end
            if (r_state == S_WAIT0 && mem_rvalid) begin
                r_rdata[31:0] <= mem_rdata;
            end
            if (r_state == S_WAIT1 && mem_rvalid) begin
                r_rdata[63:32] <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_bad ? S_RESP : S_BEAT0;
            end
            S_BEAT0: begin
                if (w_hs) begin
                    if (!r_we)        w_next = S_WAIT0;
                    else if (r_split) w_next = S_BEAT1;
                    else              w_next = S_RESP;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) w_next = r_split ? S_BEAT1 : S_RESP;
            end
            S_BEAT1: begin
                if (w_hs) w_next = r_we ? S_RESP : S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_rvalid) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    lsu_load_extend u_ext (
        .i_data   (r_rdata),
        .i_a      (r_a),
        .i_funct3 (r_f3),
        .o_result (w_ext)
    );

    // Beat fields are pure functions of state and captured request,
    // so they stay stable for as long as a beat waits on mem_ready.
    assign w_beat1   = (r_state == S_BEAT1);
    assign mem_valid = (r_state == S_BEAT0) || w_beat1;
    assign mem_we    = mem_valid && r_we;
    assign mem_addr  = !mem_valid ? 32'd0 :
                       ({r_base, 2'b00} + (w_beat1 ? 32'd4 : 32'd0));
    assign mem_wstrb = !mem_valid ? 4'd0 :
                       (w_beat1 ? r_lanes[7:4] : r_lanes[3:0]);
    assign mem_wdata = !mem_valid ? 32'd0 :
                       (w_beat1 ? r_wdata[63:32] : r_wdata[31:0]);

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_ext : 32'd0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed scoreboard bench for lsu_mem_initiator, with a second
// instance built with SPLIT_EN=0 sharing the same stimulus.
module tb_lsu_mem_initiator;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic        req_ready, rsp_valid, rsp_err, mem_valid, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        ns_ready, ns_rsp_valid, ns_rsp_err, ns_mem_valid, ns_mem_we;
    logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_wdata;
    logic [3:0]  ns_mem_wstrb;

    beat_t       exp_beat[$];
    rsp_t        exp_rsp[$];
    rsp_t        exp_ns[$];
    logic [31:0] rd_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int ns_beats = 0;
    bit pend = 0;
    bit hold = 0;
    bit spur = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_initiator #(.SPLIT_EN(1'b0)) u_ns (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(ns_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rsp_rdata),
        .rsp_err(ns_rsp_err),
        .mem_valid(ns_mem_valid), .mem_ready(mem_ready), .mem_we(ns_mem_we),
        .mem_addr(ns_mem_addr), .mem_wstrb(ns_mem_wstrb),
        .mem_wdata(ns_mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: beats and responses popped against the scoreboard
    always @(negedge clk) begin
        if (mem_valid && mem_ready) begin
            if (exp_beat.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                beat_t e;
                e = exp_beat.pop_front();
                chk("beat_addr", 64'(mem_addr), 64'(e.addr));
                chk("beat_we", 64'(mem_we), 64'(e.we));
                chk("beat_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
                chk("beat_wdata", 64'(mem_wdata), 64'(e.wdata));
            end
            if (!mem_we && !hold) pend = 1;
        end
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                rsp_t r;
                r = exp_rsp.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(r.err));
            end
        end
        if (ns_rsp_valid) begin
            if (exp_ns.size() == 0) begin
                chk("ns_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                rsp_t r;
                r = exp_ns.pop_front();
                chk("ns_rsp_rdata", 64'(ns_rsp_rdata), 64'(r.rdata));
                chk("ns_rsp_err", 64'(ns_rsp_err), 64'(r.err));
            end
        end
        if (ns_mem_valid && mem_ready) ns_beats++;
    end

    // Memory read responder: one data beat a cycle after each load handshake
    always @(posedge clk) begin
        #1;
        mem_rvalid = pend | spur;
        if (spur) mem_rdata = 32'hDEAD_BEEF;
        if (pend) begin
            if (rd_q.size() == 0) chk("rd_q_empty", 64'd1, 64'd0);
            else mem_rdata = rd_q.pop_front();
        end
        pend = 0;
    end

    task automatic push_beat(input logic [31:0] a, input logic we,
                             input logic [3:0] s, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.we = we; b.wstrb = s; b.wdata = d;
        exp_beat.push_back(b);
    endtask

    task automatic push_rsp(input logic [31:0] d, input logic e,
                            input logic [31:0] nd, input logic ne);
        rsp_t r;
        r.rdata = d; r.err = e;
        exp_rsp.push_back(r);
        r.rdata = nd; r.err = ne;
        exp_ns.push_back(r);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        while (!(req_ready === 1'b1 && ns_ready === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
        req_valid = 1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_beat.size() + exp_rsp.size() + exp_ns.size()) != 0
               && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_beat.size() + exp_rsp.size() + exp_ns.size()),
            64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        reset = 0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // SW aligned, with latency check
        push_beat(32'h10, 1, 4'b1111, 32'hA1B2C3D4);
        push_rsp(32'h0, 0, 32'h0, 0);
        issue(1, 3'b010, 32'h10, 32'hA1B2C3D4);
        @(negedge clk);
        chk("sw_beat_cycle", 64'({mem_valid, rsp_valid}), 64'b10);
        @(negedge clk);
        chk("sw_rsp_cycle", 64'({mem_valid, rsp_valid, rsp_err}), 64'b010);
        drain();

        // SB to top byte lane
        push_beat(32'h10, 1, 4'b1000, 32'hEE000000);
        push_rsp(32'h0, 0, 32'h0, 0);
        issue(1, 3'b000, 32'h13, 32'h000000EE);
        drain();

        // LH / LHU crossing a word boundary
        push_beat(32'h20, 0, 4'b1000, 32'h0);
        push_beat(32'h24, 0, 4'b0001, 32'h0);
        rd_q.push_back(32'h80FFFFFF);
        rd_q.push_back(32'h00000011);
        push_rsp(32'h00001180, 0, 32'h0, 1);
        issue(0, 3'b001, 32'h23, 32'h0);
        drain();
        push_beat(32'h20, 0, 4'b1000, 32'h0);
        push_beat(32'h24, 0, 4'b0001, 32'h0);
        rd_q.push_back(32'h80FFFFFF);
        rd_q.push_back(32'h00000011);
        push_rsp(32'h00001180, 0, 32'h0, 1);
        issue(0, 3'b101, 32'h23, 32'h0);
        drain();

        // LB / LBU sign vs zero extension
        push_beat(32'h0, 0, 4'b0100, 32'h0);
        rd_q.push_back(32'h00800000);
        push_rsp(32'hFFFFFF80, 0, 32'hFFFFFF80, 0);
        issue(0, 3'b000, 32'h02, 32'h0);
        drain();
        push_beat(32'h0, 0, 4'b0100, 32'h0);
        rd_q.push_back(32'h00800000);
        push_rsp(32'h00000080, 0, 32'h00000080, 0);
        issue(0, 3'b100, 32'h02, 32'h0);
        drain();

        // SW at top of address space: split with wrap, rejected when no split
        b0 = ns_beats;
        push_beat(32'hFFFFFFFC, 1, 4'b1100, 32'h33440000);
        push_beat(32'h00000000, 1, 4'b0011, 32'h00001122);
        push_rsp(32'h0, 0, 32'h0, 1);
        issue(1, 3'b010, 32'hFFFFFFFE, 32'h11223344);
        drain();
        chk("ns_no_beat", 64'(ns_beats - b0), 64'd0);

        // Illegal funct3: error next cycle with no beat
        push_rsp(32'h0, 1, 32'h0, 1);
        issue(0, 3'b011, 32'h30, 32'h0);
        @(negedge clk);
        chk("illegal_rsp", 64'({mem_valid, rsp_valid, rsp_err}), 64'b011);
        drain();
        push_rsp(32'h0, 1, 32'h0, 1);
        issue(1, 3'b100, 32'h30, 32'h5);
        drain();

        // Stalled store beat holds its fields
        mem_ready = 0;
        push_beat(32'h44, 1, 4'b1111, 32'h55667788);
        push_rsp(32'h0, 0, 32'h0, 0);
        issue(1, 3'b010, 32'h44, 32'h55667788);
        @(negedge clk);
        chk("stall_addr0", 64'({mem_valid, mem_addr}), {31'd0, 1'b1, 32'h44});
        @(negedge clk);
        chk("stall_addr1", 64'({mem_valid, mem_addr}), {31'd0, 1'b1, 32'h44});
        chk("stall_wdata", 64'(mem_wdata), 64'h55667788);
        @(posedge clk);
        #1 mem_ready = 1;
        drain();

        // Stray mem_rvalid while idle, then a normal LW
        spur = 1;
        @(posedge clk);
        #2 spur = 0;
        push_beat(32'h48, 0, 4'b1111, 32'h0);
        rd_q.push_back(32'hCAFE1234);
        push_rsp(32'hCAFE1234, 0, 32'hCAFE1234, 0);
        issue(0, 3'b010, 32'h48, 32'h0);
        drain();

        // Reset while waiting for load data
        hold = 1;
        push_beat(32'h40, 0, 4'b1111, 32'h0);
        issue(0, 3'b010, 32'h40, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        chk("abort_mem_valid", 64'(mem_valid), 64'd0);
        chk("abort_rsp_valid", 64'({rsp_valid, ns_rsp_valid}), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        chk("abort_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        reset = 0;
        hold = 0;
        repeat (5) @(negedge clk);
        chk("abort_idle", 64'(req_ready), 64'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
